uart_rx_1: RTL and testbench

Serial-to-parallel UART receiver, 8N1, LSB first. It is the receive counterpart of the team's `uart_tx` block and sits between the board RS-232 RX pin and the IRIG-B configuration and time-command logic. It synchronises the asynchronous line and validates the start bit at mid-bit. It then samples eight data bits and the stop bit. It presents each byte with a single-cycle valid strobe, and flags framing errors.

---
 rtl/uart_rx_1.sv | 102 ++++++++++
 tb/tb_uart_rx_1.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_1.sv
// uart_rx_1: 8N1 LSB-first UART receiver; define UART_RX_MAJORITY_EN for 2-of-3 mid-bit voting
module uart_rx_1 #(
   parameter int UART_BPS = 9600,
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       rx,
   output logic [7:0] po_data,
   output logic       po_flag,
   output logic       frame_err
);
   localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int HALF = BAUD_CNT_MAX / 2;
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [15:0] SAMPLE = 16'(HALF + 1);
`else
   localparam logic [15:0] SAMPLE = 16'(HALF);
`endif
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t      state, next;
   logic        rx_s1, rx_s, rx_d;
   logic [1:0]  warm;
   logic        armed;
   logic [15:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic        sample, bit_val, start_edge, flag_d, err_d, shift_en;
   // a line held low through reset release must rise before a start edge can count
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         rx_s1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
         warm  <= 2'b00;
         armed <= 1'b0;
      end else begin
         rx_s1 <= rx;
         rx_s  <= rx_s1;
         rx_d  <= rx_s;
         warm  <= {warm[0], 1'b1};
         armed <= armed | (warm[1] & rx_s);
      end
   assign start_edge = armed && rx_d && !rx_s;
   assign sample = (baud_cnt == SAMPLE);
`ifdef UART_RX_MAJORITY_EN
   logic v0, v1;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         v0 <= 1'b1;
         v1 <= 1'b1;
      end else begin
         if (baud_cnt == 16'(HALF - 1)) v0 <= rx_s;
         if (baud_cnt == 16'(HALF)) v1 <= rx_s;
      end
   assign bit_val = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
`else
   assign bit_val = rx_s;
`endif
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         baud_cnt <= 16'd0;
         bit_cnt  <= 4'd0;
      end else if (state == IDLE) begin
         baud_cnt <= 16'd0;
         bit_cnt  <= 4'd0;
      end else begin
         baud_cnt <= (baud_cnt == BAUD_LAST) ? 16'd0 : baud_cnt + 16'd1;
         bit_cnt  <= (baud_cnt == BAUD_LAST) ? bit_cnt + 4'd1 : bit_cnt;
      end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = start_edge ? START : IDLE;
         START:   next = sample ? (bit_val ? IDLE : DATA) : START;
         DATA:    next = (sample && bit_cnt == 4'd8) ? STOP : DATA;
         STOP:    next = sample ? IDLE : STOP;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      flag_d   = (state == STOP) && sample && bit_val;
      err_d    = (state == STOP) && sample && !bit_val;
      shift_en = (state == DATA) && sample;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         shift_reg <= 8'h00;
         po_data   <= 8'h00;
         po_flag   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         shift_reg <= shift_en ? {bit_val, shift_reg[7:1]} : shift_reg;
         po_data   <= flag_d ? shift_reg : po_data;
         po_flag   <= flag_d;
         frame_err <= err_d;
      end
endmodule

// File: tb/tb_uart_rx_1.sv
// tb_uart_rx_1: directed bench for uart_rx_1 at 16 clocks per bit
module tb_uart_rx_1;
   localparam int BPS = 1_000_000;
   localparam int CLK = 16_000_000;
   localparam int B = CLK / BPS;
   localparam int H = B / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 9 * B + H + 5;
   localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
   localparam int LAT = 9 * B + H + 4;
   localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] po_data;
   logic       po_flag, frame_err;
   int checks = 0, errors = 0;
   int cyc = 0, flag_cnt = 0, err_cnt = 0, both_cnt = 0;
   logic [7:0] dlog [64];
   int tlog [64];
   int t0;

   uart_rx_1 #(.UART_BPS(BPS), .CLK_FREQ(CLK)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx),
      .po_data(po_data), .po_flag(po_flag), .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;
   always @(negedge sys_clk) begin
      if (po_flag) begin
         dlog[flag_cnt % 64] = po_data;
         tlog[flag_cnt % 64] = cyc;
         flag_cnt++;
      end
      if (frame_err) err_cnt++;
      if (po_flag && frame_err) both_cnt++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_clks(B);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      t0 = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0;
      rx = 1'b1;
      wait_clks(4);
      checks += 3;
      if (po_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", po_data); end
      if (po_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b exp 0", po_flag); end
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", frame_err); end
      sys_rst_n = 1'b1;
      wait_clks(2 * B);
   endtask

   task automatic test_single_byte;
      int f0 = flag_cnt, e0 = err_cnt;
      send_byte(8'h55, 1'b1);
      checks += 4;
      if (flag_cnt - f0 !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", flag_cnt - f0); end
      if (dlog[f0 % 64] !== 8'h55) begin errors++; $display("FAIL single_data got %h exp 55", dlog[f0 % 64]); end
      if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_err got %0d exp 0", err_cnt - e0); end
      if (tlog[f0 % 64] - t0 < LAT - 1 || tlog[f0 % 64] - t0 > LAT + 1) begin
         errors++; $display("FAIL single_latency got %0d exp %0d", tlog[f0 % 64] - t0, LAT);
      end
      wait_clks(B);
   endtask

   task automatic test_back_to_back;
      int f0 = flag_cnt;
      send_byte(8'hA3, 1'b1);
      send_byte(8'h0F, 1'b1);
      checks += 4;
      if (flag_cnt - f0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", flag_cnt - f0); end
      if (dlog[f0 % 64] !== 8'hA3) begin errors++; $display("FAIL b2b_first got %h exp a3", dlog[f0 % 64]); end
      if (dlog[(f0 + 1) % 64] !== 8'h0F) begin errors++; $display("FAIL b2b_second got %h exp 0f", dlog[(f0 + 1) % 64]); end
      if (tlog[(f0 + 1) % 64] - tlog[f0 % 64] !== 10 * B) begin
         errors++; $display("FAIL b2b_spacing got %0d exp %0d", tlog[(f0 + 1) % 64] - tlog[f0 % 64], 10 * B);
      end
      wait_clks(B);
   endtask

   task automatic test_start_glitch;
      int f0 = flag_cnt, e0 = err_cnt;
      rx = 1'b0;
      wait_clks(5);
      rx = 1'b1;
      wait_clks(12 * B);
      checks += 4;
      if (flag_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_flag got %0d exp 0", flag_cnt - f0); end
      if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err got %0d exp 0", err_cnt - e0); end
      send_byte(8'h3C, 1'b1);
      if (flag_cnt - f0 !== 1) begin errors++; $display("FAIL glitch_next_count got %0d exp 1", flag_cnt - f0); end
      if (po_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h exp 3c", po_data); end
      wait_clks(B);
   endtask

   task automatic test_framing;
      int f0 = flag_cnt, e0 = err_cnt;
      send_byte(8'hFF, 1'b0);
      wait_clks(3 * B);
      checks += 5;
      if (err_cnt - e0 !== 1) begin errors++; $display("FAIL frame_err_count got %0d exp 1", err_cnt - e0); end
      if (flag_cnt - f0 !== 0) begin errors++; $display("FAIL frame_flag got %0d exp 0", flag_cnt - f0); end
      if (po_data !== 8'h3C) begin errors++; $display("FAIL frame_hold got %h exp 3c", po_data); end
      rx = 1'b1;
      wait_clks(2 * B);
      send_byte(8'h81, 1'b1);
      if (po_data !== 8'h81) begin errors++; $display("FAIL frame_recover got %h exp 81", po_data); end
      if (err_cnt - e0 !== 1) begin errors++; $display("FAIL frame_recover_err got %0d exp 1", err_cnt - e0); end
      wait_clks(B);
   endtask

   task automatic test_reset_mid;
      int f0, e0;
      logic [7:0] b = 8'hC6;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(b[i]);
      rx = b[3];
      wait_clks(H);
      sys_rst_n = 1'b0;
      #1;
      checks += 6;
      if (po_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", po_data); end
      if (po_flag !== 1'b0 || frame_err !== 1'b0) begin
         errors++; $display("FAIL midrst_strobes got %b%b exp 00", po_flag, frame_err);
      end
      wait_clks(3);
      f0 = flag_cnt;
      e0 = err_cnt;
      sys_rst_n = 1'b1;
      wait_clks(12 * B);
      if (flag_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_flag got %0d exp 0", flag_cnt - f0); end
      if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_err got %0d exp 0", err_cnt - e0); end
      rx = 1'b1;
      wait_clks(2 * B);
      send_byte(8'h5A, 1'b1);
      if (flag_cnt - f0 !== 1) begin errors++; $display("FAIL midrst_next_count got %0d exp 1", flag_cnt - f0); end
      if (po_data !== 8'h5A) begin errors++; $display("FAIL midrst_next_data got %h exp 5a", po_data); end
      wait_clks(B);
   endtask

   task automatic test_majority_glitch;
      int f0 = flag_cnt;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      rx = 1'b0;
      wait_clks(H + 1);
      rx = 1'b1;
      wait_clks(1);
      rx = 1'b0;
      wait_clks(B - H - 2);
      for (int i = 3; i < 8; i++) send_bit(1'b0);
      send_bit(1'b1);
      checks += 3;
      if (flag_cnt - f0 !== 1) begin errors++; $display("FAIL maj_count got %0d exp 1", flag_cnt - f0); end
      if (po_data !== GLITCH_EXP) begin errors++; $display("FAIL maj_data got %h exp %h", po_data, GLITCH_EXP); end
      if (both_cnt !== 0) begin errors++; $display("FAIL strobes_overlap got %0d exp 0", both_cnt); end
      wait_clks(B);
   endtask

   initial begin
      #1;
      test_reset;
      test_single_byte;
      test_back_to_back;
      test_start_glitch;
      test_framing;
      test_reset_mid;
      test_majority_glitch;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
